// File: rtl/wts_i2s_out.sv
// wts_i2s_out -- serialises 12-bit offset-binary stereo samples from the wave
// table sound core into a Philips-aligned I2S stream.
//
// Frame: 64 bclk = 512 clk. bclk = clk/8. lrclk low for the left slot (bits 0-31)
// and high for the right slot (bits 32-63). Each slot carries one zero bit,
// then the 12-bit two's-complement sample MSB first, then zeros.
//
// Ports:
//   clk        system clock (same as the sound core)
//   reset      asynchronous, active-high
//   in_left    left sample, offset binary (0x800 = silence)
//   in_right   right sample, offset binary
//   in_valid   sample pair present
//   in_ready   pair can be accepted this cycle (combinational, buffer not full)
//   i2s_bclk   bit clock, clk/8
//   i2s_lrclk  word select, 0 = left
//   i2s_sdata  serial data
//   underrun   one-clk pulse when a frame starts without a new pair
//
// Configuration macro WTS_I2S_SAMPLE_FIFO_EN: when defined, the input buffer is a
// 2-entry FIFO; otherwise a single holding register.
module wts_i2s_out (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] in_left,
  input  logic [11:0] in_right,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underrun
);

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
  } pair_t;

  localparam pair_t SILENCE = '{l: 12'h800, r: 12'h800};

  logic [2:0] div_cnt;
  logic [5:0] bit_cnt;
  logic [2:0] div_nxt;
  logic [5:0] bit_nxt;
  logic       load_evt;
  logic       accept;
  logic       buf_empty;
  logic       pop;
  pair_t      head;
  pair_t      in_pair;

  // Two's-complement copies of the pair currently being shifted out.
  logic [11:0] play_l;
  logic [11:0] play_r;

  assign div_nxt  = div_cnt + 3'd1;
  assign bit_nxt  = (div_cnt == 3'd7) ? bit_cnt + 6'd1 : bit_cnt;
  assign load_evt = (div_cnt == 3'd7) && (bit_cnt == 6'd63);
  assign accept   = in_valid && in_ready;
  assign pop      = load_evt && !buf_empty;
  assign in_pair  = '{l: in_left, r: in_right};

  function automatic logic [11:0] to_tc(input logic [11:0] x);
    return {~x[11], x[10:0]};
  endfunction

  // ---------------------------------------------------------------- buffer
  // The load reads only pre-edge content; a pair accepted on the load clk is
  // queued behind it, never bypassed into the shifter.
`ifdef WTS_I2S_SAMPLE_FIFO_EN
  logic [1:0] cnt;
  pair_t      f0;   // oldest
  pair_t      f1;
  logic [1:0] wr_pos;

  assign in_ready  = (cnt != 2'd2);
  assign buf_empty = (cnt == 2'd0);
  assign head      = f0;
  assign wr_pos    = pop ? cnt - 2'd1 : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      f0  <= SILENCE;
      f1  <= SILENCE;
    end else begin
      if (pop) f0 <= f1;
      if (accept) begin
        if (wr_pos == 2'd0) f0 <= in_pair;
        else                f1 <= in_pair;
      end
      cnt <= cnt + {1'b0, accept} - {1'b0, pop};
    end
  end
`else
  logic  full;
  pair_t hold;

  assign in_ready  = !full;
  assign buf_empty = !full;
  assign head      = hold;

  // accept needs !full and pop needs full, so they never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      hold <= SILENCE;
    end else begin
      if (pop) full <= 1'b0;
      if (accept) begin
        hold <= in_pair;
        full <= 1'b1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------- serialiser
  logic [4:0]  slot;
  logic [3:0]  sidx;
  logic [11:0] word;
  logic        sdata_nxt;

  // Data bit for the slot position that becomes current after this edge. On the
  // load edge the next position is slot bit 0 (always 0), so the stale play
  // registers are never visible.
  always_comb begin
    slot      = bit_nxt[4:0];
    sidx      = 4'(5'd12 - slot);
    word      = bit_nxt[5] ? play_r : play_l;
    sdata_nxt = 1'b0;
    if (slot >= 5'd1 && slot <= 5'd12) sdata_nxt = word[sidx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= 3'd0;
      bit_cnt   <= 6'd0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
      play_l    <= 12'h000;   // silence in two's complement
      play_r    <= 12'h000;
    end else begin
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      i2s_bclk <= div_nxt[2];
      underrun <= load_evt && buf_empty;
      // lrclk and sdata move only on the bclk falling edge.
      if (div_cnt == 3'd7) begin
        i2s_lrclk <= bit_nxt[5];
        i2s_sdata <= sdata_nxt;
      end
      // Empty buffer on the load edge: keep the previous pair (repeat).
      if (pop) begin
        play_l <= to_tc(head.l);
        play_r <= to_tc(head.r);
      end
    end
  end

endmodule

// File: tb/tb_wts_i2s_out.sv
module tb_wts_i2s_out;

`ifdef WTS_I2S_SAMPLE_FIFO_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] in_left = 12'h800;
  logic [11:0] in_right = 12'h800;
  logic        in_valid = 1'b0;
  logic        in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

  wts_i2s_out dut (
    .clk(clk), .reset(reset), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending pairs, the pair playing, and a clock
  // count since reset release from which frame position is derived.
  int unsigned c;
  logic [23:0] q[$];
  logic [11:0] cur_l = 12'h800, cur_r = 12'h800;
  logic        m_und = 1'b0;
  int          loads = 0;
  logic [63:0] fbits = '0;
  logic [63:0] last_frame = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h (c=%0d)", name, act, exp, c);
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model on posedge, check
  // outputs on the following negedge.
  task automatic tick(input logic v, input logic [11:0] l, input logic [11:0] r, output logic acc);
    logic rdy, ld, exp_sd;
    logic [23:0] p;
    int unsigned div, bt, s;
    logic [11:0] w;
    in_valid = v; in_left = l; in_right = r;
    #1;
    rdy = reset ? 1'b1 : (q.size() < CAP);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = v && rdy && !reset;
    @(posedge clk);
    if (reset) begin
      c = 0; q.delete(); cur_l = 12'h800; cur_r = 12'h800; m_und = 1'b0;
    end else begin
      ld = (c % 512 == 511);
      m_und = ld && (q.size() == 0);
      if (ld) begin
        last_frame = fbits;
        loads++;
        if (q.size() > 0) begin
          p = q.pop_front();
          cur_l = p[23:12]; cur_r = p[11:0];
        end
      end
      if (acc) q.push_back({l, r});
      c++;
    end
    @(negedge clk);
    if (reset) begin
      chk("reset_outs", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, underrun}, 32'd0);
    end else begin
      div = c % 8;
      bt  = (c / 8) % 64;
      s   = bt % 32;
      w   = ((bt >= 32) ? cur_r : cur_l) ^ 12'h800;
      exp_sd = (s >= 1 && s <= 12) ? w[12 - s] : 1'b0;
      chk("bclk", {31'd0, i2s_bclk}, {31'd0, div >= 4});
      chk("lrclk", {31'd0, i2s_lrclk}, {31'd0, bt >= 32});
      chk("sdata", {31'd0, i2s_sdata}, {31'd0, exp_sd});
      chk("underrun", {31'd0, underrun}, {31'd0, m_und});
      if (div == 4) fbits[bt] = i2s_sdata;
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, 12'h800, 12'h800, a);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin idle(1); n++; end
    chk("drain_timeout", {31'd0, q.size() > 0}, 32'd0);
  endtask

  task automatic wait_loads(input int target);
    int n = 0;
    while (loads < target && n < 3000) begin idle(1); n++; end
    chk("load_timeout", {31'd0, loads < target}, 32'd0);
  endtask

  // Compare the last completed frame, as seen on the wire, to the expected
  // slot words: zero bit, 12-bit sample, nineteen zeros.
  task automatic check_frame(input string name, input logic [11:0] el, input logic [11:0] er);
    logic [31:0] ol, orr;
    for (int s = 0; s < 32; s++) begin
      ol[31 - s]  = last_frame[s];
      orr[31 - s] = last_frame[32 + s];
    end
    chk({name, "_left"}, ol, {1'b0, el, 19'd0});
    chk({name, "_right"}, orr, {1'b0, er, 19'd0});
  endtask

  typedef struct {
    logic [11:0] l, r, el, er;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic a;
    int la, waitc;
    logic [31:0] rnd;

    vt[0] = '{l: 12'hFFF, r: 12'h000, el: 12'h7FF, er: 12'h800};
    vt[1] = '{l: 12'h800, r: 12'h800, el: 12'h000, er: 12'h000};
    vt[2] = '{l: 12'h000, r: 12'hFFF, el: 12'h800, er: 12'h7FF};
    vt[3] = '{l: 12'hA5A, r: 12'h5A5, el: 12'h25A, er: 12'hDA5};
    vt[4] = '{l: 12'h123, r: 12'h7FF, el: 12'h923, er: 12'hFFF};
    vt[5] = '{l: 12'h801, r: 12'h7FE, el: 12'h001, er: 12'hFFE};

    // Reset state, then two idle frames of silence with periodic underrun.
    @(negedge clk);
    idle(3);
    reset = 1'b0;
    idle(1030);
    check_frame("idle_frame", 12'h000, 12'h000);

    // Conversion / slot layout table.
    foreach (vt[i]) begin
      drain();
      a = 1'b0; waitc = 0;
      while (!a && waitc < 2000) begin tick(1'b1, vt[i].l, vt[i].r, a); waitc++; end
      chk("vec_accept", {31'd0, a}, 32'd1);
      la = loads;
      wait_loads(la + 2);
      check_frame("vec", vt[i].el, vt[i].er);
    end

    // A then B back to back.
    drain();
    tick(1'b1, 12'hA5A, 12'h5A5, a);
    chk("a_accept", {31'd0, a}, 32'd1);
    la = loads;
    a = 1'b0; waitc = 0;
    while (!a && waitc < 600) begin tick(1'b1, 12'h3C3, 12'hC3C, a); waitc++; end
    chk("b_accept", {31'd0, a}, 32'd1);
`ifdef WTS_I2S_SAMPLE_FIFO_EN
    chk("b_wait", waitc, 32'd1);
    tick(1'b1, 12'h111, 12'h222, a);
    chk("c_stall", {31'd0, a}, 32'd0);
`else
    chk("b_waited", {31'd0, waitc > 1}, 32'd1);
    chk("b_after_load", (c - 1) % 512, 32'd0);
`endif
    wait_loads(la + 2);
    check_frame("frame_a", 12'h25A, 12'hDA5);
    wait_loads(la + 3);
    check_frame("frame_b", 12'hBC3, 12'h43C);

    // Pair offered exactly on the load clk with an empty buffer.
    drain();
    while (c % 512 != 511) idle(1);
    tick(1'b1, 12'h0F0, 12'hF0F, a);
    chk("late_accept", {31'd0, a}, 32'd1);
    chk("late_underrun", {31'd0, underrun}, 32'd1);
    la = loads;
    wait_loads(la + 1);
    check_frame("late_repeat", 12'hBC3, 12'h43C);
    wait_loads(la + 2);
    check_frame("late_play", 12'h8F0, 12'h70F);

    // Reset mid left slot with a pair pending.
    drain();
    tick(1'b1, 12'hFFF, 12'hFFF, a);
    while (c % 512 != 160) idle(1);
    reset = 1'b1;
    #1;
    chk("async_reset", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, underrun}, 32'd0);
    idle(3);
    reset = 1'b0;
    la = loads;
    wait_loads(la + 2);
    check_frame("post_reset", 12'h000, 12'h000);

    // Randomised traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      rnd = $urandom;
      tick(($urandom_range(0, 199) < 3), rnd[11:0], rnd[23:12], a);
    end
    idle(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
